rgmii_rx_decoder: RTL and testbench

Receive-side counterpart of the team's speed-adaptive RGMII transmitter. Consumes RGMII beats already captured by IDDR and moved into the clk_125mhz domain by an upstream CDC FIFO (one beat per rgmii_rxc cycle). Assembles bytes for 10/100/1000 Mbps, strips preamble/SFD, flags errors, and emits each frame as an AXI-Stream byte stream with tlast/tuser. While RX_DV is low it also decodes PHY in-band link, speed and duplex status.

---
 rtl/rgmii_pkg.sv | 34 +++
 rtl/rgmii_crc32_byte.sv | 27 ++
 rtl/rgmii_rx_decoder.sv | 230 +++++++++++++++++++++++
 tb/tb_rgmii_rx_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII receive path: speed codes,
// preamble/SFD bytes, CRC-32 constants and the receive FSM states.
`timescale 1ns/1ps

package rgmii_pkg;

    localparam logic [1:0] SPEED_10M   = 2'd0;
    localparam logic [1:0] SPEED_100M  = 2'd1;
    localparam logic [1:0] SPEED_1000M = 2'd2;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    // Good-frame residue, expressed in MSB-first bit order.
    localparam logic [31:0] CRC32_RESIDUE   = 32'hC704_DD7B;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } rx_state_t;

    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rgmii_crc32_byte.sv
// Combinational byte-wise CRC-32 step, LSB-first (reflected) form,
// used by rgmii_rx_decoder when RGMII_RX_FCS_CHECK_EN is defined.
`timescale 1ns/1ps

module rgmii_crc32_byte
    import rgmii_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_next = c;
    end

endmodule

// File: rtl/rgmii_rx_decoder.sv
// RGMII receive decoder: byte assembly, preamble/SFD strip, AXI-Stream out.
// Optional FCS check is enabled by defining RGMII_RX_FCS_CHECK_EN.
`timescale 1ns/1ps

module rgmii_rx_decoder
    import rgmii_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 1522,
    parameter int CNT_W           = 11
) (
    input  logic       clk_125mhz,
    input  logic       reset,
    input  logic [1:0] rx_speed,
    input  logic       rx_beat_valid,
    input  logic [3:0] rx_beat_d1,
    input  logic [3:0] rx_beat_d2,
    input  logic       rx_beat_ctl1,
    input  logic       rx_beat_ctl2,
    output logic [7:0] m_axis_rgmii_tdata,
    output logic       m_axis_rgmii_tvalid,
    output logic       m_axis_rgmii_tlast,
    output logic       m_axis_rgmii_tuser,
    output logic       phy_link_status,
    output logic [1:0] phy_speed_status,
    output logic       phy_duplex_status
);

    rx_state_t state_q;
    rx_state_t state_d;

    logic             beat;
    logic             dv;
    logic             er;
    logic             gig;
    logic [1:0]       speed_q;
    logic             phase_q;
    logic [3:0]       lo_q;
    logic             byte_ok;
    logic [7:0]       byte_val;
    logic             start;
    logic             push;
    logic             ovf;
    logic             end_frame;
    logic             data_er;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             flush_q;
    logic [7:0]       hold_q;
    logic             hold_valid_q;
    logic             crc_bad;
    logic             frame_bad;

    assign beat = rx_beat_valid;
    assign dv   = rx_beat_ctl1;
    assign er   = rx_beat_ctl1 ^ rx_beat_ctl2;

    // Speed is frozen for the whole frame; IDLE follows the live input.
    assign gig = ((state_q == IDLE) ? rx_speed : speed_q) == SPEED_1000M;

    assign byte_ok  = beat && dv && (gig || phase_q);
    assign byte_val = gig ? {rx_beat_d2, rx_beat_d1}
                          : {rx_beat_d1, lo_q};

    assign data_er = (state_q == DATA) && beat && dv && er;

`ifdef RGMII_RX_FCS_CHECK_EN
    logic [31:0] crc_q;
    logic [31:0] crc_d;

    rgmii_crc32_byte u_crc (
        .crc      (crc_q),
        .data     (byte_val),
        .crc_next (crc_d)
    );

    always_ff @(posedge clk_125mhz) begin
        if (reset || start) begin
            crc_q <= CRC32_INIT;
        end else if (push) begin
            crc_q <= crc_d;
        end
    end

    assign crc_bad = bit_reverse32(crc_q) != CRC32_RESIDUE;
`else
    assign crc_bad = 1'b0;
`endif

    // A pending low nibble at DV fall means the frame ended mid-byte.
    assign frame_bad = err_q || phase_q || crc_bad;

    always_ff @(posedge clk_125mhz) begin
        if (reset) begin
            state_q <= IDLE;
            speed_q <= SPEED_10M;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                speed_q <= rx_speed;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        push      = 1'b0;
        ovf       = 1'b0;
        end_frame = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (beat && dv) begin
                    state_d = PRE;
                end
            end
            PRE: begin
                if (beat && !dv) begin
                    state_d = IDLE;
                end else if (beat && er) begin
                    state_d = DROP;
                end else if (byte_ok) begin
                    if (byte_val == SFD_BYTE) begin
                        state_d = DATA;
                        start   = 1'b1;
                    end else if (byte_val != PREAMBLE_BYTE) begin
                        state_d = DROP;
                    end
                end
            end
            DATA: begin
                if (beat && !dv) begin
                    state_d   = IDLE;
                    end_frame = 1'b1;
                end else if (byte_ok) begin
                    push = 1'b1;
                    if (cnt_q == CNT_W'(MAX_FRAME_BYTES)) begin
                        ovf     = 1'b1;
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (beat && !dv) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_125mhz) begin
        if (reset) begin
            phase_q <= 1'b0;
            lo_q    <= '0;
        end else if (beat) begin
            if (!dv || gig) begin
                phase_q <= 1'b0;
            end else if (phase_q) begin
                phase_q <= 1'b0;
            end else begin
                phase_q <= 1'b1;
                lo_q    <= rx_beat_d1;
            end
        end
    end

    always_ff @(posedge clk_125mhz) begin
        if (reset) begin
            phy_link_status   <= 1'b0;
            phy_speed_status  <= '0;
            phy_duplex_status <= 1'b0;
        end else if (beat && !dv && !er) begin
            phy_link_status   <= rx_beat_d1[0];
            phy_speed_status  <= rx_beat_d1[2:1];
            phy_duplex_status <= rx_beat_d1[3];
        end
    end

    // One-byte hold lets the final byte carry tlast once DV falls.
    always_ff @(posedge clk_125mhz) begin
        if (reset) begin
            m_axis_rgmii_tdata  <= '0;
            m_axis_rgmii_tvalid <= 1'b0;
            m_axis_rgmii_tlast  <= 1'b0;
            m_axis_rgmii_tuser  <= 1'b0;
            hold_q              <= '0;
            hold_valid_q        <= 1'b0;
            flush_q             <= 1'b0;
            cnt_q               <= '0;
            err_q               <= 1'b0;
        end else begin
            m_axis_rgmii_tvalid <= 1'b0;
            m_axis_rgmii_tlast  <= 1'b0;
            m_axis_rgmii_tuser  <= 1'b0;
            if (flush_q) begin
                m_axis_rgmii_tdata  <= hold_q;
                m_axis_rgmii_tvalid <= 1'b1;
                m_axis_rgmii_tlast  <= 1'b1;
                m_axis_rgmii_tuser  <= 1'b1;
                hold_valid_q        <= 1'b0;
                flush_q             <= 1'b0;
            end
            if (start) begin
                cnt_q        <= '0;
                err_q        <= 1'b0;
                hold_valid_q <= 1'b0;
            end
            if (data_er) begin
                err_q <= 1'b1;
            end
            if (push) begin
                cnt_q        <= cnt_q + CNT_W'(1);
                hold_q       <= byte_val;
                hold_valid_q <= 1'b1;
                flush_q      <= ovf;
                if (hold_valid_q) begin
                    m_axis_rgmii_tdata  <= hold_q;
                    m_axis_rgmii_tvalid <= 1'b1;
                end
            end
            if (end_frame && hold_valid_q) begin
                m_axis_rgmii_tdata  <= hold_q;
                m_axis_rgmii_tvalid <= 1'b1;
                m_axis_rgmii_tlast  <= 1'b1;
                m_axis_rgmii_tuser  <= frame_bad;
                hold_valid_q        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// Directed bench for rgmii_rx_decoder with an expected-byte scoreboard.
// Covers 10/100/1000 framing, errors, overflow, status and reset.
`timescale 1ns/1ps

module tb_rgmii_rx_decoder;
    import rgmii_pkg::*;

    localparam int MAXB = 1522;

    logic       clk_125mhz = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rx_speed = SPEED_1000M;
    logic       rx_beat_valid = 1'b0;
    logic [3:0] rx_beat_d1 = '0;
    logic [3:0] rx_beat_d2 = '0;
    logic       rx_beat_ctl1 = 1'b0;
    logic       rx_beat_ctl2 = 1'b0;
    logic [7:0] m_axis_rgmii_tdata;
    logic       m_axis_rgmii_tvalid;
    logic       m_axis_rgmii_tlast;
    logic       m_axis_rgmii_tuser;
    logic       phy_link_status;
    logic [1:0] phy_speed_status;
    logic       phy_duplex_status;

    always #4 clk_125mhz = ~clk_125mhz;

    rgmii_rx_decoder #(
        .MAX_FRAME_BYTES (MAXB),
        .CNT_W           (11)
    ) dut (
        .clk_125mhz          (clk_125mhz),
        .reset               (reset),
        .rx_speed            (rx_speed),
        .rx_beat_valid       (rx_beat_valid),
        .rx_beat_d1          (rx_beat_d1),
        .rx_beat_d2          (rx_beat_d2),
        .rx_beat_ctl1        (rx_beat_ctl1),
        .rx_beat_ctl2        (rx_beat_ctl2),
        .m_axis_rgmii_tdata  (m_axis_rgmii_tdata),
        .m_axis_rgmii_tvalid (m_axis_rgmii_tvalid),
        .m_axis_rgmii_tlast  (m_axis_rgmii_tlast),
        .m_axis_rgmii_tuser  (m_axis_rgmii_tuser),
        .phy_link_status     (phy_link_status),
        .phy_speed_status    (phy_speed_status),
        .phy_duplex_status   (phy_duplex_status)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fr[$];
    int         n_checks = 0;
    int         n_pass = 0;
    bit         gap_en = 1'b0;
    logic       fcs_en;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h",
                    tag, obs, exp);
    endtask

    always @(negedge clk_125mhz) begin
        exp_t e;
        if (m_axis_rgmii_tvalid === 1'b1) begin
            check("out_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("tdata", 32'(m_axis_rgmii_tdata), 32'(e.d));
                check("tlast", 32'(m_axis_rgmii_tlast), 32'(e.l));
                if (e.l) begin
                    check("tuser", 32'(m_axis_rgmii_tuser), 32'(e.u));
                end
            end
        end
    end

    task automatic beat(input logic [3:0] a, input logic [3:0] b,
                        input logic c1, input logic c2);
        if (gap_en) begin
            rx_beat_valid = 1'b0;
            rx_beat_d1    = 4'($urandom);
            rx_beat_d2    = 4'($urandom);
            rx_beat_ctl1  = 1'($urandom);
            rx_beat_ctl2  = 1'($urandom);
            @(posedge clk_125mhz); #1;
        end
        rx_beat_valid = 1'b1;
        rx_beat_d1    = a;
        rx_beat_d2    = b;
        rx_beat_ctl1  = c1;
        rx_beat_ctl2  = c2;
        @(posedge clk_125mhz); #1;
        rx_beat_valid = 1'b0;
    endtask

    task automatic gbyte(input logic [7:0] v, input logic e);
        beat(v[3:0], v[7:4], 1'b1, ~e);
    endtask

    task automatic nib(input logic [3:0] n);
        beat(n, 4'h0, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) beat(4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic gig_preamble();
        repeat (7) gbyte(PREAMBLE_BYTE, 1'b0);
        gbyte(SFD_BYTE, 1'b0);
    endtask

    task automatic send_gig(input int er_idx);
        gig_preamble();
        foreach (fr[i]) gbyte(fr[i], i == er_idx);
        idle(3);
    endtask

    task automatic send_nib(input bit odd);
        repeat (15) nib(4'h5);
        nib(4'hD);
        foreach (fr[i]) begin
            nib(fr[i][3:0]);
            nib(fr[i][7:4]);
        end
        if (odd) nib(4'h3);
        idle(3);
    endtask

    task automatic expect_frame(input int n, input logic u);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d = fr[i];
            e.l = (i == n - 1);
            e.u = (i == n - 1) && u;
            sb.push_back(e);
        end
    endtask

    function automatic logic [31:0] fcs_of_frame();
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (fr[i]) begin
            c = c ^ {24'd0, fr[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t        e;
        logic [31:0] fcs;
`ifdef RGMII_RX_FCS_CHECK_EN
        fcs_en = 1'b1;
`else
        fcs_en = 1'b0;
`endif
        repeat (3) @(posedge clk_125mhz);
        #1;
        beat(4'hF, 4'h0, 1'b0, 1'b0);
        check("rst_tdata",  32'(m_axis_rgmii_tdata), 0);
        check("rst_tvalid", 32'(m_axis_rgmii_tvalid), 0);
        check("rst_tlast",  32'(m_axis_rgmii_tlast), 0);
        check("rst_tuser",  32'(m_axis_rgmii_tuser), 0);
        check("rst_link",   32'(phy_link_status), 0);
        check("rst_speed",  32'(phy_speed_status), 0);
        check("rst_duplex", 32'(phy_duplex_status), 0);
        reset = 1'b0;
        idle(4);

        // 1000M, 60-byte counting payload
        fr.delete();
        for (int i = 1; i <= 60; i++) fr.push_back(8'(i));
        expect_frame(60, 1'b0);
        send_gig(-1);

        // 100M, two bytes; then same with a trailing odd nibble
        rx_speed = SPEED_100M;
        idle(2);
        fr = '{8'h01, 8'h02};
        expect_frame(2, 1'b0);
        send_nib(1'b0);
        expect_frame(2, 1'b1);
        send_nib(1'b1);

        // 10M with idle gaps between beats
        rx_speed = SPEED_10M;
        idle(2);
        gap_en = 1'b1;
        fr = '{8'hA5, 8'h3C, 8'h7E};
        expect_frame(3, 1'b0);
        send_nib(1'b0);
        gap_en = 1'b0;

        // 1000M, ER on payload byte 10
        rx_speed = SPEED_1000M;
        idle(2);
        fr.delete();
        for (int i = 0; i < 20; i++) fr.push_back(8'(8'h80 + i));
        expect_frame(20, 1'b1);
        send_gig(10);

        // 1000M with gaps
        gap_en = 1'b1;
        fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        expect_frame(5, 1'b0);
        send_gig(-1);
        gap_en = 1'b0;

        // in-band status while DV is low
        rx_speed = SPEED_10M;
        idle(1);
        check("st_link_pre", 32'(phy_link_status), 0);
        beat(4'b1101, 4'h0, 1'b0, 1'b0);
        check("st_link",   32'(phy_link_status), 1);
        check("st_speed",  32'(phy_speed_status), 2);
        check("st_duplex", 32'(phy_duplex_status), 1);
        beat(4'b0010, 4'h0, 1'b0, 1'b1);
        check("st_er_hold", 32'(phy_speed_status), 2);
        rx_beat_d1 = 4'b0000;
        @(posedge clk_125mhz); #1;
        check("st_novalid_hold", 32'(phy_link_status), 1);
        beat(4'b0110, 4'h0, 1'b0, 1'b0);
        check("st_link2",   32'(phy_link_status), 0);
        check("st_speed3",  32'(phy_speed_status), 3);
        check("st_duplex2", 32'(phy_duplex_status), 0);

        // speed change mid-frame keeps the old speed
        rx_speed = SPEED_1000M;
        idle(2);
        fr.delete();
        for (int i = 0; i < 16; i++) fr.push_back(8'(8'hF0 ^ i));
        expect_frame(16, 1'b0);
        gig_preamble();
        for (int i = 0; i < 8; i++) gbyte(fr[i], 1'b0);
        rx_speed = SPEED_100M;
        for (int i = 8; i < 16; i++) gbyte(fr[i], 1'b0);
        idle(3);
        fr = '{8'h12, 8'h34};
        expect_frame(2, 1'b0);
        send_nib(1'b0);

        // zero-length, ER in preamble, bad preamble: no output
        rx_speed = SPEED_1000M;
        idle(2);
        gig_preamble();
        idle(3);
        repeat (3) gbyte(PREAMBLE_BYTE, 1'b0);
        gbyte(PREAMBLE_BYTE, 1'b1);
        gbyte(SFD_BYTE, 1'b0);
        gbyte(8'h12, 1'b0);
        idle(3);
        repeat (3) gbyte(PREAMBLE_BYTE, 1'b0);
        gbyte(8'h57, 1'b0);
        gbyte(SFD_BYTE, 1'b0);
        gbyte(8'h34, 1'b0);
        idle(3);
        fr = '{8'hC3};
        expect_frame(1, 1'b0);
        send_gig(-1);

        // exactly MAX bytes, then MAX+5 (overflow), then recovery
        fr.delete();
        for (int i = 0; i < MAXB; i++) fr.push_back(8'(i * 3));
        expect_frame(MAXB, 1'b0);
        send_gig(-1);
        fr.delete();
        for (int i = 0; i < MAXB + 5; i++) fr.push_back(8'(i));
        expect_frame(MAXB + 1, 1'b1);
        send_gig(-1);
        fr = '{8'h5A, 8'hA5};
        expect_frame(2, 1'b0);
        send_gig(-1);

        // 64-byte frame with valid FCS, then one bit flipped
        fr.delete();
        for (int i = 0; i < 60; i++) fr.push_back(8'(i * 7 + 3));
        fcs = fcs_of_frame();
        fr.push_back(fcs[7:0]);
        fr.push_back(fcs[15:8]);
        fr.push_back(fcs[23:16]);
        fr.push_back(fcs[31:24]);
        expect_frame(64, 1'b0);
        send_gig(-1);
        fr[20] = fr[20] ^ 8'h10;
        expect_frame(64, fcs_en);
        send_gig(-1);

        // reset mid-frame: bytes already shifted out stay, no tlast
        gig_preamble();
        e.d = 8'hA1; e.l = 1'b0; e.u = 1'b0;
        sb.push_back(e);
        e.d = 8'hA2;
        sb.push_back(e);
        gbyte(8'hA1, 1'b0);
        gbyte(8'hA2, 1'b0);
        gbyte(8'hA3, 1'b0);
        reset = 1'b1;
        gbyte(8'hA4, 1'b0);
        check("midrst_tvalid", 32'(m_axis_rgmii_tvalid), 0);
        check("midrst_tlast",  32'(m_axis_rgmii_tlast), 0);
        reset = 1'b0;
        gbyte(8'hA5, 1'b0);
        gbyte(8'hA6, 1'b0);
        idle(5);

        check("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
